// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the serial memory read path.
// Holds the controller state encoding and the READ command framing.
package spi_mem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PWRUP,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_GAP
   } state_t;

   localparam logic [7:0] SPI_OP_READ = 8'h03;
   localparam int         ADDR_W      = 24;
   localparam int         HDR_BITS    = 32;
   localparam int         HDR_BYTES   = HDR_BITS / 8;

endpackage

// File: rtl/spi_bit_engine.sv
// Mode-0 SPI bit engine: clock divider plus one-byte transmit and receive shifters.
// A new byte is pulled from tx_byte on load and on every byte wrap.
module spi_bit_engine #(
   parameter int CLK_DIV = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       load,
   input  logic       stall,
   input  logic [7:0] tx_byte,
   input  logic       miso,
   output logic       sclk,
   output logic       mosi,
   output logic       byte_done,
   output logic [7:0] rx_byte
);

   localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       tx_shift;
   logic [7:0]       rx_shift;
   logic             phase_end;
   logic             hold_rise;
   logic             rise;
   logic             fall;

   // Stall only gates the first rising edge of a byte, so a byte in flight always completes.
   assign phase_end = (div_cnt == DIV_LAST);
   assign hold_rise = stall && (bit_cnt == 3'd0);
   assign rise      = enable && !load && !sclk && phase_end && !hold_rise;
   assign fall      = enable && !load && sclk && phase_end;
   assign byte_done = rise && (bit_cnt == 3'd7);
   assign rx_byte   = {rx_shift[6:0], miso};
   assign mosi      = tx_shift[7];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk     <= 1'b0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
         tx_shift <= '0;
         rx_shift <= '0;
      end else if (load) begin
         tx_shift <= tx_byte;
         sclk     <= 1'b0;
         div_cnt  <= '0;
         bit_cnt  <= '0;
      end else if (!enable) begin
         sclk    <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
      end else if (rise) begin
         sclk     <= 1'b1;
         div_cnt  <= '0;
         rx_shift <= rx_byte;
      end else if (fall) begin
         sclk     <= 1'b0;
         div_cnt  <= '0;
         bit_cnt  <= bit_cnt + 3'd1;
         tx_shift <= (bit_cnt == 3'd7) ? tx_byte : {tx_shift[6:0], 1'b0};
      end else if (!phase_end) begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/spi_mem_reader.sv
// SPI READ engine: powers the serial memory, sends opcode plus address and
// streams the returned bytes out through a single-entry valid/ready register.
module spi_mem_reader
   import spi_mem_pkg::*;
#(
   parameter int CLK_DIV        = 2,
   parameter int PWRUP_CYCLES   = 1000,
   parameter int CS_HIGH_CYCLES = 4,
   parameter int LEN_W          = 16
) (
   input  logic              CLKA,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              MEM_VCC,
   output logic              SPI_CLK,
   output logic              SPI_MOSI,
   input  logic              SPI_MISO,
   output logic              SPI_CS_n
);

   localparam logic [31:0] PWR_LAST = 32'(PWRUP_CYCLES - 1);
   localparam logic [31:0] GAP_LAST = 32'(CS_HIGH_CYCLES - 1);

   state_t             state;
   state_t             state_next;
   logic [ADDR_W-1:0]  addr_q;
   logic [LEN_W-1:0]   remaining;
   logic [2:0]         byte_idx;
   logic [31:0]        wait_cnt;
   logic               powered;
   logic               mem_vcc_q;
   logic               eng_enable;
   logic               eng_load;
   logic               byte_done;
   logic [7:0]         tx_byte;
   logic [7:0]         rx_byte;
   logic               accept;
   logic               handshake;

   assign accept     = (state == ST_IDLE) && start && (len != '0);
   assign handshake  = rd_valid && rd_ready;
   assign eng_enable = (state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA);
   assign busy       = (state != ST_IDLE);
   assign SPI_CS_n   = !eng_enable;
   assign MEM_VCC    = mem_vcc_q;

   spi_bit_engine #(
      .CLK_DIV (CLK_DIV)
   ) u_engine (
      .clk       (CLKA),
      .rst_n     (rst_n),
      .enable    (eng_enable),
      .load      (eng_load),
      .stall     (rd_valid),
      .tx_byte   (tx_byte),
      .miso      (SPI_MISO),
      .sclk      (SPI_CLK),
      .mosi      (SPI_MOSI),
      .byte_done (byte_done),
      .rx_byte   (rx_byte)
   );

   // Header bytes by position; everything after the address shifts out zeros.
   always_comb begin
      tx_byte = 8'h00;
      case (byte_idx)
         3'd0:    tx_byte = SPI_OP_READ;
         3'd1:    tx_byte = addr_q[23:16];
         3'd2:    tx_byte = addr_q[15:8];
         3'd3:    tx_byte = addr_q[7:0];
         default: tx_byte = 8'h00;
      endcase
   end

   always_ff @(posedge CLKA or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // The engine is loaded on the very edge that enters CMD so CS_n and the opcode MSB appear together.
   always_comb begin
      state_next = state;
      eng_load   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (powered) begin
                  state_next = ST_CMD;
                  eng_load   = 1'b1;
               end else begin
                  state_next = ST_PWRUP;
               end
            end
         end
         ST_PWRUP: begin
            if (wait_cnt == PWR_LAST) begin
               state_next = ST_CMD;
               eng_load   = 1'b1;
            end
         end
         ST_CMD: begin
            if (byte_done) state_next = ST_ADDR;
         end
         ST_ADDR: begin
            if (byte_done && (byte_idx == 3'(HDR_BYTES - 1))) state_next = ST_DATA;
         end
         ST_DATA: begin
            if (handshake && (remaining == LEN_W'(1))) state_next = ST_GAP;
         end
         ST_GAP: begin
            if (wait_cnt == GAP_LAST) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLKA or negedge rst_n) begin
      if (!rst_n) begin
         addr_q    <= '0;
         remaining <= '0;
         byte_idx  <= '0;
         wait_cnt  <= '0;
         powered   <= 1'b0;
         mem_vcc_q <= 1'b0;
         done      <= 1'b0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
      end else begin
         done <= 1'b0;
         if ((state == ST_IDLE) && start) begin
            if (len == '0) begin
               done <= 1'b1;
            end else begin
               addr_q    <= addr;
               remaining <= len;
               mem_vcc_q <= 1'b1;
            end
         end
         if ((state != state_next) || !((state == ST_PWRUP) || (state == ST_GAP))) begin
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + 32'd1;
         end
         if ((state == ST_PWRUP) && (state_next == ST_CMD)) powered <= 1'b1;
         if ((state == ST_GAP) && (state_next == ST_IDLE)) done <= 1'b1;
         if (state == ST_IDLE) begin
            byte_idx <= '0;
         end else if (byte_done && (byte_idx != 3'(HDR_BYTES))) begin
            byte_idx <= byte_idx + 3'd1;
         end
         if (handshake) begin
            rd_valid  <= 1'b0;
            remaining <= remaining - LEN_W'(1);
         end
         if (byte_done && (state == ST_DATA)) begin
            rd_data  <= rx_byte;
            rd_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_mem_reader.sv
// Self-checking bench for spi_mem_reader: a serial memory model answers READs,
// and every transaction is scored against the framing and byte stream it should produce.
module tb_spi_mem_reader;

   localparam int CLK_DIV        = 2;
   localparam int PWRUP_CYCLES   = 300;
   localparam int CS_HIGH_CYCLES = 4;
   localparam int LEN_W          = 16;
   localparam int CYCLE_BUDGET   = 8000;

   logic             CLKA = 1'b0;
   logic             rst_n;
   logic             start;
   logic [23:0]      addr;
   logic [LEN_W-1:0] len;
   logic             busy;
   logic             done;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic             rd_ready;
   logic             MEM_VCC;
   logic             SPI_CLK;
   logic             SPI_MOSI;
   logic             SPI_MISO = 1'b0;
   logic             SPI_CS_n;

   int         checkCount = 0;
   int         errorCount = 0;
   logic [7:0] misoBytes[$];
   int         negCount   = 0;
   bit         inTxn      = 1'b0;

   spi_mem_reader #(
      .CLK_DIV        (CLK_DIV),
      .PWRUP_CYCLES   (PWRUP_CYCLES),
      .CS_HIGH_CYCLES (CS_HIGH_CYCLES),
      .LEN_W          (LEN_W)
   ) dut (
      .CLKA     (CLKA),
      .rst_n    (rst_n),
      .start    (start),
      .addr     (addr),
      .len      (len),
      .busy     (busy),
      .done     (done),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_ready (rd_ready),
      .MEM_VCC  (MEM_VCC),
      .SPI_CLK  (SPI_CLK),
      .SPI_MOSI (SPI_MOSI),
      .SPI_MISO (SPI_MISO),
      .SPI_CS_n (SPI_CS_n)
   );

   always #5 CLKA = ~CLKA;

   // Memory model: after the 32 header bits it shifts out misoBytes MSB-first on SPI_CLK falling edges.
   always @(negedge SPI_CLK or SPI_CS_n) begin
      int k;
      if (SPI_CS_n === 1'b1) begin
         inTxn = 1'b0;
      end else if (!inTxn) begin
         inTxn    = 1'b1;
         negCount = 0;
      end else if (SPI_CLK === 1'b0) begin
         negCount++;
         if (negCount >= 32) begin
            k = negCount - 32;
            if (k / 8 < misoBytes.size()) SPI_MISO = misoBytes[k / 8][7 - (k % 8)];
            else SPI_MISO = 1'b0;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic fillMiso(input int n);
      misoBytes.delete();
      for (int i = 0; i < n; i++) misoBytes.push_back(8'($urandom));
   endtask

   // readyMode: 0 always ready, 1 random ready, 2 ready held low 50 cycles after the first byte.
   task automatic applyStimulus(input logic [23:0] a, input int n, input int readyMode,
                                input bit expectPwrup, input bit injectStarts);
      logic [31:0] header = '0;
      logic [7:0]  rx[$];
      logic [7:0]  dataPrev = '0;
      int rises = 0, cyc = 0, vccCyc = -1, csCyc = -1, csRiseCyc = -1, doneCyc = -1;
      int doneCount = 0, bpLeft = 0, violations = 0, busyErrors = 0;
      bit bpDone = 1'b0, sclkPrev = 1'b0, mosiPrev = 1'b0, validPrev = 1'b0, hsPrev = 1'b0, vccPrev;
      bit hs;
      vccPrev  = MEM_VCC;
      rd_ready = 1'b1;
      @(posedge CLKA); #1;
      start = 1'b1;
      addr  = a;
      len   = LEN_W'(n);
      @(posedge CLKA); #1;
      start = 1'b0;
      addr  = 24'($urandom);
      len   = LEN_W'($urandom);
      while (cyc < CYCLE_BUDGET && (doneCyc < 0 || cyc < doneCyc + 3)) begin
         @(negedge CLKA);
         cyc++;
         if (MEM_VCC && !vccPrev && vccCyc < 0) vccCyc = cyc;
         if (!SPI_CS_n && csCyc < 0) csCyc = cyc;
         if (SPI_CS_n && csCyc >= 0 && csRiseCyc < 0) csRiseCyc = cyc;
         if (SPI_CS_n && csCyc >= 0 && rx.size() < n) violations++;
         if (done) begin
            doneCount++;
            if (doneCyc < 0) doneCyc = cyc;
         end
         if (busy !== (doneCyc < 0)) busyErrors++;
         if (SPI_CLK && !sclkPrev) begin
            if (rises < 32) header = {header[30:0], SPI_MOSI};
            rises++;
            if (validPrev) violations++;
         end
         if (SPI_CLK && sclkPrev && SPI_MOSI !== mosiPrev) violations++;
         if (validPrev && !hsPrev && (!rd_valid || rd_data !== dataPrev)) violations++;
         if (bpLeft > 0 && bpLeft < 50 - 2 * CLK_DIV && (SPI_CLK || SPI_CS_n)) violations++;
         case (readyMode)
            1: rd_ready = ($urandom_range(0, 3) != 0);
            2: begin
               if (rd_valid && rx.size() == 0 && !bpDone) begin
                  bpLeft = 50;
                  bpDone = 1'b1;
               end
               if (bpLeft > 0) begin
                  rd_ready = 1'b0;
                  bpLeft--;
               end else begin
                  rd_ready = 1'b1;
               end
            end
            default: rd_ready = 1'b1;
         endcase
         hs = rd_valid && rd_ready;
         if (hs) rx.push_back(rd_data);
         if (injectStarts && busy && doneCyc < 0 && $urandom_range(0, 7) == 0) begin
            start = 1'b1;
            addr  = 24'($urandom);
            len   = LEN_W'($urandom_range(0, 9));
         end else begin
            start = 1'b0;
         end
         hsPrev    = hs;
         sclkPrev  = SPI_CLK;
         mosiPrev  = SPI_MOSI;
         validPrev = rd_valid;
         dataPrev  = rd_data;
         vccPrev   = MEM_VCC;
      end
      start    = 1'b0;
      rd_ready = 1'b1;
      checkOutput("done_seen", 32'(doneCyc >= 0), 32'd1);
      checkOutput("done_count", doneCount, 1);
      checkOutput("busy_track", busyErrors, 0);
      checkOutput("mosi_header", header, {8'h03, a});
      checkOutput("sclk_rises", rises, 32 + 8 * n);
      checkOutput("rx_count", rx.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < rx.size()) checkOutput($sformatf("rx_byte%0d", i), rx[i], misoBytes[i]);
      end
      checkOutput("protocol", violations, 0);
      checkOutput("cs_gap", 32'(doneCyc - csRiseCyc >= CS_HIGH_CYCLES), 32'd1);
      if (expectPwrup) begin
         checkOutput("pwrup_delay", csCyc - vccCyc, PWRUP_CYCLES);
      end else begin
         checkOutput("cs_latency", csCyc, 1);
      end
      checkOutput("vcc_on", MEM_VCC, 1);
   endtask

   task automatic applyZeroLen();
      int csLow = 0, sclkHigh = 0, vccChanged = 0, extraDone = 0;
      logic vccBefore;
      vccBefore = MEM_VCC;
      @(posedge CLKA); #1;
      start = 1'b1;
      addr  = 24'($urandom);
      len   = '0;
      @(posedge CLKA); #1;
      start = 1'b0;
      @(negedge CLKA);
      checkOutput("zero_done", done, 1);
      checkOutput("zero_busy", busy, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge CLKA);
         if (!SPI_CS_n) csLow++;
         if (SPI_CLK) sclkHigh++;
         if (MEM_VCC !== vccBefore) vccChanged++;
         if (done || busy) extraDone++;
      end
      checkOutput("zero_quiet", csLow + sclkHigh + vccChanged + extraDone, 0);
   endtask

   initial begin
      int riseCnt;
      int cyc;
      bit prevClk;
      rst_n    = 1'b0;
      start    = 1'b0;
      addr     = '0;
      len      = '0;
      rd_ready = 1'b1;
      repeat (3) @(posedge CLKA);
      @(negedge CLKA);
      checkOutput("rst_cs_n", SPI_CS_n, 1);
      checkOutput("rst_flags", {busy, done, rd_valid, MEM_VCC, SPI_CLK, SPI_MOSI}, 0);
      checkOutput("rst_rd_data", rd_data, 0);
      @(posedge CLKA); #1;
      rst_n = 1'b1;

      $display("[TB] cold start read");
      misoBytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
      applyStimulus(24'h000100, 4, 0, 1'b1, 1'b0);

      $display("[TB] powered read");
      fillMiso(2);
      applyStimulus(24'h123456, 2, 0, 1'b0, 1'b0);

      $display("[TB] backpressure read");
      fillMiso(3);
      applyStimulus(24'($urandom), 3, 2, 1'b0, 1'b0);

      $display("[TB] zero length request");
      applyZeroLen();

      $display("[TB] start pulses while busy");
      fillMiso(4);
      applyStimulus(24'($urandom), 4, 1, 1'b0, 1'b1);

      $display("[TB] reset during address phase");
      fillMiso(3);
      @(posedge CLKA); #1;
      start = 1'b1;
      addr  = 24'hABCDEF;
      len   = LEN_W'(3);
      @(posedge CLKA); #1;
      start   = 1'b0;
      riseCnt = 0;
      cyc     = 0;
      prevClk = 1'b0;
      while (riseCnt < 12 && cyc < CYCLE_BUDGET) begin
         @(negedge CLKA);
         cyc++;
         if (SPI_CLK && !prevClk) riseCnt++;
         prevClk = SPI_CLK;
      end
      checkOutput("reached_addr", riseCnt, 12);
      rst_n = 1'b0;
      #1;
      checkOutput("arst_cs_n", SPI_CS_n, 1);
      checkOutput("arst_flags", {busy, rd_valid, MEM_VCC, SPI_CLK}, 0);
      @(posedge CLKA); #1;
      rst_n = 1'b1;

      $display("[TB] cold start after reset");
      fillMiso(2);
      applyStimulus(24'($urandom), 2, 0, 1'b1, 1'b0);

      $display("[TB] randomized reads");
      for (int t = 0; t < 5; t++) begin
         int n;
         n = $urandom_range(1, 5);
         fillMiso(n);
         applyStimulus(24'($urandom), n, $urandom_range(0, 1), 1'b0, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
